// File: rtl/contador_pkg.sv
`default_nettype none
// ============================================================================
// Module   : contador_pkg
// Purpose  : Shared types and default widths for the ripple-counter
//            controller (state encoding, counter and reload widths).
// Revision : 1.0  initial release
// ============================================================================
package contador_pkg;

    // Default width of the counter value and terminal-count limit
    localparam int c_CNT_W_DEF = 11;

    // Default width of the saturating auto-reload event counter
    localparam int c_RLD_W_DEF = 8;

    // Controller states, 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_TERM  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/contador_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : contador_ctrl
// Purpose  : Run controller for an external JK ripple counter. Clears the
//            counter, enables toggling until the latched limit is reached,
//            pulses done, and optionally restarts (auto-reload) while
//            counting reload events with saturation.
// Revision : 1.0  initial release
// ============================================================================
module contador_ctrl
    import contador_pkg::*;
#(
    parameter int CNT_W = c_CNT_W_DEF,
    parameter int RLD_W = c_RLD_W_DEF
) (
    input  logic             Clo,
    input  logic             Clr,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             auto_reload,
    input  logic [CNT_W-1:0] limit,
    input  logic [CNT_W-1:0] cnt,
    output logic             jk_en,
    output logic             cnt_clr,
    output logic             busy,
    output logic             done,
    output logic [RLD_W-1:0] reload_cnt
);

    localparam logic [RLD_W-1:0] c_RLD_MAX = '1;
    localparam logic [RLD_W-1:0] c_RLD_ONE = {{(RLD_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_limit;
    logic [RLD_W-1:0] r_reload_cnt;
    logic             r_done;
    logic             r_cnt_clr;
    logic             r_busy;

    logic             w_jk_en;
    logic             w_term_hit;
    logic             w_start_ok;
    logic             w_start_zero;
    logic             w_reload;
    logic             w_done_nxt;
    logic             w_cnt_clr_nxt;
    logic             w_busy_nxt;
    logic [CNT_W-1:0] w_limit_m1;

    // Toggle enable is the only combinational output; reset also masks it so
    // the counter never advances while Clr is held.
    assign w_jk_en      = (r_state == ST_RUN) & ~pause & ~abort & ~Clr;
    // Fire one count early: the enabling edge itself lands the counter on
    // exactly limit. Because jk_en already folds in pause, pause wins.
    assign w_limit_m1   = r_limit - c_CNT_ONE;
    assign w_term_hit   = w_jk_en & (cnt == w_limit_m1);
    assign w_start_ok   = (r_state == ST_IDLE) & start & (limit != '0);
    assign w_start_zero = (r_state == ST_IDLE) & start & (limit == '0);
    // An abort during TERM still lets done through but cancels the restart
    assign w_reload     = (r_state == ST_TERM) & auto_reload & ~abort;

    // State register; done/cnt_clr/busy are registered from the next state
    always_ff @(posedge Clo) begin
        if (Clr) begin
            r_state   <= ST_IDLE;
            r_done    <= 1'b0;
            r_cnt_clr <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= w_done_nxt;
            r_cnt_clr <= w_cnt_clr_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Next-state decode; abort leaves the counter untouched (straight to IDLE)
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_state_nxt = abort ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_term_hit) begin
                    w_state_nxt = ST_TERM;
                end
            end
            ST_TERM: begin
                w_state_nxt = w_reload ? ST_CLEAR : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so registered outputs align with it
    always_comb begin
        w_done_nxt    = (w_state_nxt == ST_TERM) | w_start_zero;
        w_cnt_clr_nxt = (w_state_nxt == ST_CLEAR);
        w_busy_nxt    = (w_state_nxt != ST_IDLE);
    end

    // Limit latch on accepted start and saturating reload-event counter
    always_ff @(posedge Clo) begin
        if (Clr) begin
            r_limit      <= '0;
            r_reload_cnt <= '0;
        end else if (w_start_ok) begin
            r_limit      <= limit;
            r_reload_cnt <= '0;
        end else if (w_reload && (r_reload_cnt != c_RLD_MAX)) begin
            r_reload_cnt <= r_reload_cnt + c_RLD_ONE;
        end
    end

    assign jk_en      = w_jk_en;
    assign cnt_clr    = r_cnt_clr;
    assign busy       = r_busy;
    assign done       = r_done;
    assign reload_cnt = r_reload_cnt;

endmodule
`default_nettype wire

// File: tb/tb_contador_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_contador_ctrl
// Purpose  : Directed self-checking bench for contador_ctrl with a
//            behavioural model of the external ripple counter. A second
//            instance with RLD_W=2 exercises reload saturation.
// Revision : 1.0  initial release
// ============================================================================
module tb_contador_ctrl;

    localparam int CNT_W = 11;

    logic             Clo = 1'b0;
    logic             Clr;
    logic             start;
    logic             pause;
    logic             abort;
    logic             auto_reload;
    logic [CNT_W-1:0] limit;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt2;
    logic             jk_en, cnt_clr, busy, done;
    logic             jk_en2, cnt_clr2, busy2, done2;
    logic [7:0]       reload_cnt;
    logic [1:0]       reload_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0]      o_jk, o_clr, o_done, o_busy;
    logic [CNT_W-1:0] o_cnt [64];
    logic [7:0]       o_rl  [64];
    logic [1:0]       o_rl2 [64];

    logic [63:0]      e_jk, e_clr, e_done, e_busy;

    always #5 Clo = ~Clo;

    contador_ctrl #(.CNT_W(CNT_W), .RLD_W(8)) u_dut (
        .Clo(Clo), .Clr(Clr), .start(start), .pause(pause), .abort(abort),
        .auto_reload(auto_reload), .limit(limit), .cnt(cnt),
        .jk_en(jk_en), .cnt_clr(cnt_clr), .busy(busy), .done(done),
        .reload_cnt(reload_cnt)
    );

    contador_ctrl #(.CNT_W(CNT_W), .RLD_W(2)) u_dut_r2 (
        .Clo(Clo), .Clr(Clr), .start(start), .pause(pause), .abort(abort),
        .auto_reload(auto_reload), .limit(limit), .cnt(cnt2),
        .jk_en(jk_en2), .cnt_clr(cnt_clr2), .busy(busy2), .done(done2),
        .reload_cnt(reload_cnt2)
    );

    // External JK ripple counters: synchronous clear, toggle-enable increment
    always @(posedge Clo) begin
        if (Clr || cnt_clr)  cnt <= '0;
        else if (jk_en)      cnt <= cnt + 1'b1;
        if (Clr || cnt_clr2) cnt2 <= '0;
        else if (jk_en2)     cnt2 <= cnt2 + 1'b1;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive per-cycle stimulus (bit i applies to cycle i) and record outputs
    // mid-cycle. Called just after a rising edge; cycle 0 starts there.
    task automatic run_obs(input int n, input logic [63:0] st, input logic [63:0] pz,
                           input logic [63:0] ab, input logic [63:0] rs,
                           input logic [CNT_W-1:0] lim_late);
        o_jk = '0; o_clr = '0; o_done = '0; o_busy = '0;
        for (int i = 0; i < n; i++) begin
            start = st[i];
            pause = pz[i];
            abort = ab[i];
            Clr   = rs[i];
            if (i == 1) limit = lim_late;
            @(negedge Clo);
            o_jk[i]   = jk_en;
            o_clr[i]  = cnt_clr;
            o_done[i] = done;
            o_busy[i] = busy;
            o_cnt[i]  = cnt;
            o_rl[i]   = reload_cnt;
            o_rl2[i]  = reload_cnt2;
            @(posedge Clo);
            #1;
        end
        start = 1'b0; pause = 1'b0; abort = 1'b0; Clr = 1'b0;
    endtask

    task automatic check_vecs(input string tag);
        check_eq({tag, "_jk_en"},   o_jk,   e_jk);
        check_eq({tag, "_cnt_clr"}, o_clr,  e_clr);
        check_eq({tag, "_done"},    o_done, e_done);
        check_eq({tag, "_busy"},    o_busy, e_busy);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with every control input asserted: Clr must override them
        Clr = 1'b1; start = 1'b1; pause = 1'b1; abort = 1'b1;
        auto_reload = 1'b0; limit = 11'd5;
        repeat (2) @(posedge Clo);
        #1;
        @(negedge Clo);
        check_eq("rst_busy",    64'(busy),       64'h0);
        check_eq("rst_done",    64'(done),       64'h0);
        check_eq("rst_cnt_clr", 64'(cnt_clr),    64'h0);
        check_eq("rst_jk_en",   64'(jk_en),      64'h0);
        check_eq("rst_reload",  64'(reload_cnt), 64'h0);
        @(posedge Clo);
        #1;
        Clr = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
        @(posedge Clo);
        #1;

        // Basic count run, limit 5, no reload
        limit = 11'd5; auto_reload = 1'b0;
        run_obs(9, 64'h1, 64'h0, 64'h0, 64'h0, 11'd5);
        e_jk = 64'h7C; e_clr = 64'h2; e_done = 64'h80; e_busy = 64'hFE;
        check_vecs("run5");
        check_eq("run5_final_cnt", 64'(o_cnt[8]), 64'd5);

        // Pause in cycles 6-8; cycle 6 is also the terminal-hit cycle
        limit = 11'd5;
        run_obs(12, 64'h1, 64'h1C0, 64'h0, 64'h0, 11'd5);
        e_jk = 64'h23C; e_clr = 64'h2; e_done = 64'h400; e_busy = 64'h7FE;
        check_vecs("pause");
        check_eq("pause_final_cnt", 64'(o_cnt[11]), 64'd5);

        // Auto-reload, limit 3; start while busy in cycle 8 with limit now 7
        // must be ignored; abort in the fifth TERM ends the run without reload
        limit = 11'd3; auto_reload = 1'b1;
        run_obs(28, 64'h101, 64'h0, 64'h200_0000, 64'h0, 11'd7);
        e_jk = '0; e_clr = '0; e_done = '0; e_busy = '0;
        for (int k = 0; k < 5; k++) begin
            e_clr[5*k+1]  = 1'b1;
            e_done[5*k+5] = 1'b1;
            for (int j = 2; j <= 4; j++) e_jk[5*k+j] = 1'b1;
            for (int j = 1; j <= 5; j++) e_busy[5*k+j] = 1'b1;
        end
        check_vecs("reload");
        check_eq("reload_cnt_c16",     64'(o_rl[16]),  64'd3);
        check_eq("reload_cnt_r2_c16",  64'(o_rl2[16]), 64'd3);
        check_eq("reload_cnt_c21",     64'(o_rl[21]),  64'd4);
        check_eq("reload_cnt_r2_sat",  64'(o_rl2[21]), 64'd3);
        check_eq("reload_abort_term",  64'(o_rl[26]),  64'd4);
        auto_reload = 1'b0;

        // Zero limit: single done pulse, never busy
        limit = 11'd0;
        run_obs(4, 64'h1, 64'h0, 64'h0, 64'h0, 11'd0);
        e_jk = 64'h0; e_clr = 64'h0; e_done = 64'h2; e_busy = 64'h0;
        check_vecs("zero");

        // Abort in RUN with counter at 2
        limit = 11'd5;
        run_obs(7, 64'h1, 64'h0, 64'h10, 64'h0, 11'd5);
        e_jk = 64'h0C; e_clr = 64'h2; e_done = 64'h0; e_busy = 64'h1E;
        check_vecs("abort");
        check_eq("abort_cnt_at_abort", 64'(o_cnt[4]), 64'd2);
        check_eq("abort_cnt_held",     64'(o_cnt[6]), 64'd2);

        // Clr mid-run with reload enabled: immediate IDLE, no done
        limit = 11'd5; auto_reload = 1'b1;
        run_obs(12, 64'h1, 64'h0, 64'h0, 64'h10, 11'd5);
        e_jk = 64'h0C; e_clr = 64'h2; e_done = 64'h0; e_busy = 64'h1E;
        check_vecs("clr_mid");
        check_eq("clr_mid_reload", 64'(o_rl[11]), 64'd0);
        auto_reload = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
